uart_tx_frame_seq: RTL



---
 rtl/uart_tx_pkg.sv | 20 ++
 rtl/uart_tx_frame_seq_if.sv | 28 ++
 rtl/uart_tx_line_sel.sv | 24 ++
 rtl/uart_tx_frame_seq.sv | 138 +++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit frame sequencer:
// FSM state encoding, line-select codes and the idle line level.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [1:0] SEL_START = 2'd0;
  localparam logic [1:0] SEL_DATA  = 2'd1;
  localparam logic [1:0] SEL_PAR   = 2'd2;
  localparam logic [1:0] SEL_STOP  = 2'd3;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_tx_frame_seq_if.sv
// Handshake/line bundle for the UART TX frame sequencer.
// Optional feature macro: UART_TX_STOP2_EN adds the stop2 request bit.
interface uart_tx_frame_seq_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  data_valid;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  par_en;
  logic                  par_typ;
`ifdef UART_TX_STOP2_EN
  logic                  stop2;
`endif
  logic                  tx_out;
  logic                  busy;

`ifdef UART_TX_STOP2_EN
  modport master (output data_valid, p_data, par_en, par_typ, stop2,
                  input  tx_out, busy);
  modport slave  (input  data_valid, p_data, par_en, par_typ, stop2,
                  output tx_out, busy);
`else
  modport master (output data_valid, p_data, par_en, par_typ,
                  input  tx_out, busy);
  modport slave  (input  data_valid, p_data, par_en, par_typ,
                  output tx_out, busy);
`endif

endinterface

// File: rtl/uart_tx_line_sel.sv
// Combinational line selector: maps a select code and the candidate
// bit values to the next serial line level.
module uart_tx_line_sel
  import uart_tx_pkg::*;
(
  input  logic [1:0] sel,
  input  logic       data_bit,
  input  logic       par_bit,
  output logic       line
);

  // pick the line level for the selected frame field
  always_comb begin
    line = LINE_IDLE;
    case (sel)
      SEL_START: line = 1'b0;
      SEL_DATA:  line = data_bit;
      SEL_PAR:   line = par_bit;
      SEL_STOP:  line = LINE_IDLE;
      default:   line = LINE_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_tx_frame_seq.sv
// UART transmit frame sequencer: start, DATA_WIDTH data bits (LSB first),
// optional runtime parity and stop bit(s); one clock per bit period.
// tx_out and busy are registered from the next state so they line up with it.
// Optional feature macro: UART_TX_STOP2_EN enables a second stop bit.
module uart_tx_frame_seq #(
  parameter int DATA_WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  uart_tx_frame_seq_if.slave bus
);
  import uart_tx_pkg::*;

  localparam int              CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  state_t                state_q;
  state_t                state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  final_stop;
  logic                  accept;
  logic                  par_bit;
  logic [1:0]            sel_d;
  logic                  busy_d;
  logic                  data_bit_d;
  logic                  line_d;
  logic                  tx_q;
  logic                  busy_q;

`ifdef UART_TX_STOP2_EN
  logic                  stop2_q;
  logic                  stop_first_q;

  // a two-stop frame finishes only on its second STOP cycle
  assign final_stop = (state_q == STOP) && (!stop2_q || stop_first_q);
`else
  assign final_stop = (state_q == STOP);
`endif

  // new frames are taken when idle or during the last stop bit (back-to-back)
  assign accept = bus.data_valid && ((state_q == IDLE) || final_stop);

  // even parity is the XOR of the payload; odd is its complement
  assign par_bit = par_typ_q ? ~^data_reg : ^data_reg;

  // counter clears in START, steps through DATA, never wraps past the last bit
  assign cnt_d = (state_q == START) ? '0 :
                 ((state_q == DATA) && (cnt_q != CNT_LAST)) ? cnt_q + 1'b1 :
                 cnt_q;

  // state register
  always_ff @(posedge CLK) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   state_d = DATA;
      DATA:    if (cnt_q == CNT_LAST) state_d = par_en_q ? PARITY : STOP;
      PARITY:  state_d = STOP;
      STOP:    if (final_stop) state_d = accept ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // line select and busy for the upcoming state; idle shares the stop level
  always_comb begin
    sel_d  = SEL_STOP;
    busy_d = 1'b1;
    case (state_d)
      IDLE:    begin sel_d = SEL_STOP; busy_d = 1'b0; end
      START:   sel_d = SEL_START;
      DATA:    sel_d = SEL_DATA;
      PARITY:  sel_d = SEL_PAR;
      STOP:    sel_d = SEL_STOP;
      default: begin sel_d = SEL_STOP; busy_d = 1'b0; end
    endcase
  end

  assign data_bit_d = data_reg[cnt_d];

  uart_tx_line_sel u_line_sel (
    .sel      (sel_d),
    .data_bit (data_bit_d),
    .par_bit  (par_bit),
    .line     (line_d)
  );

  // bit counter and per-frame latches captured on accept
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q     <= '0;
      data_reg  <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
`ifdef UART_TX_STOP2_EN
      stop2_q      <= 1'b0;
      stop_first_q <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        data_reg  <= bus.p_data;
        par_en_q  <= bus.par_en;
        par_typ_q <= bus.par_typ;
`ifdef UART_TX_STOP2_EN
        stop2_q   <= bus.stop2;
`endif
      end
`ifdef UART_TX_STOP2_EN
      stop_first_q <= (state_q == STOP) && !final_stop;
`endif
    end
  end

  // registered line and busy outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      tx_q   <= LINE_IDLE;
      busy_q <= 1'b0;
    end else begin
      tx_q   <= line_d;
      busy_q <= busy_d;
    end
  end

  assign bus.tx_out = tx_q;
  assign bus.busy   = busy_q;

endmodule
